// File: rtl/uart_tx_engine_if.sv
// Handshake and serial-line bundle for uart_tx_engine.
// UART_TX_BREAK_EN adds the BREAK request line.
interface uart_tx_engine_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  STOP2;
    logic                  TX_OUT;
    logic                  busy;
    logic                  frame_done;
`ifdef UART_TX_BREAK_EN
    logic                  BREAK;
`endif

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP2,
`ifdef UART_TX_BREAK_EN
        output BREAK,
`endif
        input  TX_OUT, busy, frame_done
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP2,
`ifdef UART_TX_BREAK_EN
        input  BREAK,
`endif
        output TX_OUT, busy, frame_done
    );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmitter: frame sequencing, LSB-first serialisation and parity, one bit per CLK.
// Optional line-break generation is enabled with UART_TX_BREAK_EN.
module uart_tx_engine #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 4
) (
    input logic             CLK,
    input logic             RST,
    uart_tx_engine_if.slave bus
);

    // Encoding keeps the common path (idle->start->data->parity->stop) to single-bit steps.
    typedef enum logic [2:0] {
        StIdle   = 3'b000,
        StStart  = 3'b001,
        StData   = 3'b011,
        StParity = 3'b010,
        StStop1  = 3'b110,
`ifdef UART_TX_BREAK_EN
        StBrk    = 3'b100,
`endif
        StStop2  = 3'b111
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(DATA_WIDTH - 1);

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  stop2_q, stop2_d;
`ifdef UART_TX_BREAK_EN
    logic                  brk_q, brk_d;
`endif
    logic                  final_cycle;
    logic                  accept;
    logic                  data_bit;
    logic                  tx;

    always_comb begin
        final_cycle = (state_q == StStop2) || ((state_q == StStop1) && !stop2_q);
`ifdef UART_TX_BREAK_EN
        // The stop cycle that closes a break is not a frame end.
        if (brk_q) final_cycle = 1'b0;
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        stop2_d   = stop2_q;
`ifdef UART_TX_BREAK_EN
        brk_d     = brk_q;
`endif
        accept    = 1'b0;

        case (state_q)
            StIdle: begin
`ifdef UART_TX_BREAK_EN
                if (bus.BREAK) begin
                    state_d = StBrk;
                    brk_d   = 1'b1;
                    stop2_d = 1'b0;
                end else
`endif
                if (bus.Data_Valid) accept = 1'b1;
            end
            StStart: state_d = StData;
            StData: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = par_en_q ? StParity : StStop1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StParity: state_d = StStop1;
            StStop1: begin
                if (stop2_q) state_d = StStop2;
`ifdef UART_TX_BREAK_EN
                else if (brk_q) begin
                    state_d = StIdle;
                    brk_d   = 1'b0;
                end
`endif
            end
            StStop2: ;
`ifdef UART_TX_BREAK_EN
            StBrk: if (!bus.BREAK) state_d = StStop1;
`endif
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        if (final_cycle) begin
            if (bus.Data_Valid) accept = 1'b1;
            else state_d = StIdle;
        end

        if (accept) begin
            state_d   = StStart;
            cnt_d     = '0;
            data_d    = bus.P_DATA;
            par_en_d  = bus.PAR_EN;
            par_typ_d = bus.PAR_TYP;
            stop2_d   = bus.STOP2;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            stop2_q   <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            stop2_q   <= stop2_d;
`ifdef UART_TX_BREAK_EN
            brk_q     <= brk_d;
`endif
        end
    end

    always_comb begin
        data_bit = 1'b0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            if (cnt_q == CNT_WIDTH'(i)) data_bit = data_q[i];
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state_q)
            StStart:  tx = 1'b0;
            StData:   tx = data_bit;
            StParity: tx = (^data_q) ^ par_typ_q;
`ifdef UART_TX_BREAK_EN
            StBrk:    tx = 1'b0;
`endif
            default:  tx = 1'b1;
        endcase
    end

    assign bus.TX_OUT     = tx;
    assign bus.busy       = (state_q != StIdle);
    assign bus.frame_done = final_cycle;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: reset, framing, parity, back-to-back, ignore, widths.
module tb_uart_tx_engine;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 CLK = ~CLK;

    uart_tx_engine_if #(.DATA_WIDTH(8)) b8 ();
    uart_tx_engine_if #(.DATA_WIDTH(5)) b5 ();
    uart_tx_engine_if #(.DATA_WIDTH(9)) b9 ();

    uart_tx_engine #(.DATA_WIDTH(8), .CNT_WIDTH(4)) u8 (.CLK(CLK), .RST(RST), .bus(b8));
    uart_tx_engine #(.DATA_WIDTH(5), .CNT_WIDTH(3)) u5 (.CLK(CLK), .RST(RST), .bus(b5));
    uart_tx_engine #(.DATA_WIDTH(9), .CNT_WIDTH(4)) u9 (.CLK(CLK), .RST(RST), .bus(b9));

    task automatic init_inputs();
        b8.P_DATA = '0; b8.Data_Valid = 0; b8.PAR_EN = 0; b8.PAR_TYP = 0; b8.STOP2 = 0;
        b5.P_DATA = '0; b5.Data_Valid = 0; b5.PAR_EN = 0; b5.PAR_TYP = 0; b5.STOP2 = 0;
        b9.P_DATA = '0; b9.Data_Valid = 0; b9.PAR_EN = 0; b9.PAR_TYP = 0; b9.STOP2 = 0;
`ifdef UART_TX_BREAK_EN
        b8.BREAK = 0; b5.BREAK = 0; b9.BREAK = 0;
`endif
    endtask

    task automatic test_reset();
        #2 RST = 1'b0;
        #1;
        total++;
        if ({b8.TX_OUT, b8.busy, b8.frame_done} !== 3'b100) begin
            bad++;
            $display("FAIL reset_w8 got tx/busy/done=%b want 100",
                     {b8.TX_OUT, b8.busy, b8.frame_done});
        end
        total++;
        if ({b5.TX_OUT, b5.busy, b5.frame_done, b9.TX_OUT, b9.busy, b9.frame_done} !== 6'b100100)
        begin
            bad++;
            $display("FAIL reset_w5w9 got %b want 100100",
                     {b5.TX_OUT, b5.busy, b5.frame_done, b9.TX_OUT, b9.busy, b9.frame_done});
        end
        repeat (2) @(negedge CLK);
        RST = 1'b1;

        // Start a frame of zeros, then pull reset while in DATA.
        b8.P_DATA = 8'h00; b8.Data_Valid = 1;
        @(posedge CLK); #1 b8.Data_Valid = 0;
        repeat (3) @(negedge CLK);
        total++;
        if ({b8.TX_OUT, b8.busy} !== 2'b01) begin
            bad++;
            $display("FAIL pre_reset_data got tx/busy=%b want 01", {b8.TX_OUT, b8.busy});
        end
        #2 RST = 1'b0;
        #1;
        total++;
        if ({b8.TX_OUT, b8.busy, b8.frame_done} !== 3'b100) begin
            bad++;
            $display("FAIL reset_mid_frame got tx/busy/done=%b want 100",
                     {b8.TX_OUT, b8.busy, b8.frame_done});
        end
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            total++;
            if ({b8.TX_OUT, b8.busy, b8.frame_done} !== 3'b100) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got tx/busy/done=%b want 100", i,
                         {b8.TX_OUT, b8.busy, b8.frame_done});
            end
        end
    endtask

    task automatic test_basic();
        logic [0:15] e = 16'b0101_0010_1100_0000;
        @(negedge CLK);
        b8.P_DATA = 8'hA5; b8.PAR_EN = 0; b8.STOP2 = 0; b8.Data_Valid = 1;
        @(posedge CLK); #1 b8.Data_Valid = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            total++;
            if ({b8.TX_OUT, b8.busy, b8.frame_done} !== {e[i], 1'b1, i == 9}) begin
                bad++;
                $display("FAIL basic cyc=%0d got tx/busy/done=%b want %b", i,
                         {b8.TX_OUT, b8.busy, b8.frame_done}, {e[i], 1'b1, i == 9});
            end
        end
        @(negedge CLK);
        total++;
        if ({b8.TX_OUT, b8.busy, b8.frame_done} !== 3'b100) begin
            bad++;
            $display("FAIL basic_after got tx/busy/done=%b want 100",
                     {b8.TX_OUT, b8.busy, b8.frame_done});
        end
    endtask

    task automatic test_parity();
        logic [0:15] e_even = 16'b0111_0000_0110_0000;
        logic [0:15] e_odd  = 16'b0111_0000_0010_0000;
        for (int t = 0; t < 2; t++) begin
            @(negedge CLK);
            b8.P_DATA = 8'h07; b8.PAR_EN = 1; b8.PAR_TYP = t[0]; b8.STOP2 = 0;
            b8.Data_Valid = 1;
            @(posedge CLK); #1 b8.Data_Valid = 0;
            for (int i = 0; i < 11; i++) begin
                logic eb;
                eb = (t == 0) ? e_even[i] : e_odd[i];
                @(negedge CLK);
                total++;
                if ({b8.TX_OUT, b8.busy, b8.frame_done} !== {eb, 1'b1, i == 10}) begin
                    bad++;
                    $display("FAIL parity typ=%0d cyc=%0d got tx/busy/done=%b want %b", t, i,
                             {b8.TX_OUT, b8.busy, b8.frame_done}, {eb, 1'b1, i == 10});
                end
            end
            @(negedge CLK);
            total++;
            if (b8.busy !== 1'b0) begin
                bad++;
                $display("FAIL parity_after typ=%0d got busy=%b want 0", t, b8.busy);
            end
        end
        b8.PAR_EN = 0; b8.PAR_TYP = 0;
    endtask

    task automatic test_back_to_back();
        logic [0:31] e = 32'b0000_0000_0110_1111_1111_1100_0000_0000;
        @(negedge CLK);
        b8.P_DATA = 8'h00; b8.PAR_EN = 0; b8.STOP2 = 1; b8.Data_Valid = 1;
        for (int i = 0; i < 22; i++) begin
            @(negedge CLK);
            total++;
            if ({b8.TX_OUT, b8.busy, b8.frame_done} !== {e[i], 1'b1, (i == 10) || (i == 21)})
            begin
                bad++;
                $display("FAIL b2b cyc=%0d got tx/busy/done=%b want %b", i,
                         {b8.TX_OUT, b8.busy, b8.frame_done},
                         {e[i], 1'b1, (i == 10) || (i == 21)});
            end
            if (i == 0) b8.P_DATA = 8'hFF;
            if (i == 12) b8.Data_Valid = 0;
        end
        @(negedge CLK);
        total++;
        if ({b8.TX_OUT, b8.busy} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_after got tx/busy=%b want 10", {b8.TX_OUT, b8.busy});
        end
        b8.STOP2 = 0;
    endtask

    task automatic test_ignore();
        logic [0:15] e = 16'b0101_0010_1100_0000;
        @(negedge CLK);
        b8.P_DATA = 8'hA5; b8.PAR_EN = 0; b8.STOP2 = 0; b8.Data_Valid = 1;
        @(posedge CLK); #1 b8.Data_Valid = 0;
        for (int i = 0; i < 14; i++) begin
            logic eb;
            logic eby;
            eb  = (i < 10) ? e[i] : 1'b1;
            eby = (i < 10);
            @(negedge CLK);
            total++;
            if ({b8.TX_OUT, b8.busy, b8.frame_done} !== {eb, eby, i == 9}) begin
                bad++;
                $display("FAIL ignore cyc=%0d got tx/busy/done=%b want %b", i,
                         {b8.TX_OUT, b8.busy, b8.frame_done}, {eb, eby, i == 9});
            end
            if (i == 3) begin
                b8.P_DATA = 8'h3C; b8.PAR_EN = 1; b8.Data_Valid = 1;
            end
            if (i == 4) b8.Data_Valid = 0;
        end
        b8.PAR_EN = 0;
    endtask

    task automatic test_width();
        logic [0:15] e5 = 16'b0111_1101_0000_0000;
        logic [0:15] e9 = 16'b0111_1111_1101_0000;
        @(negedge CLK);
        b5.P_DATA = 5'h1F;  b5.PAR_EN = 1; b5.PAR_TYP = 1; b5.STOP2 = 0; b5.Data_Valid = 1;
        b9.P_DATA = 9'h1FF; b9.PAR_EN = 1; b9.PAR_TYP = 1; b9.STOP2 = 0; b9.Data_Valid = 1;
        @(posedge CLK); #1 b5.Data_Valid = 0; b9.Data_Valid = 0;
        for (int i = 0; i < 13; i++) begin
            logic [2:0] x5;
            logic [2:0] x9;
            x5 = (i < 8)  ? {e5[i], 1'b1, i == 7}  : 3'b100;
            x9 = (i < 12) ? {e9[i], 1'b1, i == 11} : 3'b100;
            @(negedge CLK);
            total++;
            if ({b5.TX_OUT, b5.busy, b5.frame_done} !== x5) begin
                bad++;
                $display("FAIL width5 cyc=%0d got tx/busy/done=%b want %b", i,
                         {b5.TX_OUT, b5.busy, b5.frame_done}, x5);
            end
            total++;
            if ({b9.TX_OUT, b9.busy, b9.frame_done} !== x9) begin
                bad++;
                $display("FAIL width9 cyc=%0d got tx/busy/done=%b want %b", i,
                         {b9.TX_OUT, b9.busy, b9.frame_done}, x9);
            end
        end
    endtask

    initial begin
        init_inputs();
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_ignore();
        test_width();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
